// File: rtl/conv_pool_flatten_pkg.sv
// conv_pkg: shared csel encodings, FSM states and default sizes for the pool/flatten stage.
package conv_pkg;

    localparam int IMG_W_DEF  = 64;
    localparam int DATA_W_DEF = 20;

    localparam logic [2:0] CSEL_IDLE = 3'b000;
    localparam logic [2:0] CSEL_L0K0 = 3'b001;
    localparam logic [2:0] CSEL_L0K1 = 3'b010;
    localparam logic [2:0] CSEL_L1K0 = 3'b011;
    localparam logic [2:0] CSEL_L1K1 = 3'b100;
    localparam logic [2:0] CSEL_L2   = 3'b101;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD0,
        S_RD1,
        S_RD2,
        S_RD3,
        S_CMP,
        S_WL1,
        S_WL2,
        S_DONE
    } state_t;

endpackage

// File: rtl/conv_pool_flatten_if.sv
// conv_pool_flatten_if: shared result-memory port (read, write and memory select).
interface conv_pool_flatten_if
    import conv_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = DATA_W_DEF
);
    logic              crd;
    logic [ADDR_W-1:0] caddr_rd;
    logic [DATA_W-1:0] cdata_rd;
    logic              cwr;
    logic [ADDR_W-1:0] caddr_wr;
    logic [DATA_W-1:0] cdata_wr;
    logic [2:0]        csel;

    modport master(output crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel, input cdata_rd);
    modport slave(input crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel, output cdata_rd);
endinterface

// File: rtl/conv_pool_flatten_pool_max4.sv
// pool_max4: signed running-max register; load takes the first pixel, update keeps the larger (ties hold).
module pool_max4
    import conv_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              update,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] max_q
);
    always_ff @(posedge clk or negedge reset)
        if (!reset) max_q <= '0;
        else if (load || (update && $signed(din) > $signed(max_q))) max_q <= din;
endmodule

// File: rtl/conv_pool_flatten.sv
// conv_pool_flatten: 2x2 max-pool of both layer-0 maps into layer 1, plus interleaved flatten to layer 2.
// POOL_FLATTEN_EN enables the layer-2 write state; without it each item ends after the layer-1 write.
module conv_pool_flatten
    import conv_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    output logic                done,
    conv_pool_flatten_if.master cm
);
    localparam int HW = $clog2(IMG_W) - 1;
    localparam int PW = 2 * HW;
`ifdef POOL_FLATTEN_EN
    localparam state_t S_LAST = S_WL2;
`else
    localparam state_t S_LAST = S_WL1;
`endif

    state_t            state, state_n;
    logic [PW:0]       item;
    logic [HW-1:0]     r, c;
    logic              k, last, rd, wr1, wr2, row, col;
    logic [DATA_W-1:0] max_q;

    // item = {p, k}: kernel is the low bit, so incrementing walks k inside p
    assign {r, c, k} = item;
    assign last = &item;
    assign rd   = state inside {S_RD0, S_RD1, S_RD2, S_RD3};
    assign wr1  = state == S_WL1;
`ifdef POOL_FLATTEN_EN
    assign wr2  = state == S_WL2;
`else
    assign wr2  = 1'b0;
`endif
    assign row  = state inside {S_RD2, S_RD3};
    assign col  = state inside {S_RD1, S_RD3};

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state <= S_IDLE;
            item  <= '0;
        end else begin
            state <= state_n;
            if (state == S_LAST) item <= item + 1'b1;
        end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:  state_n = start ? S_RD0 : S_IDLE;
            S_RD0:   state_n = S_RD1;
            S_RD1:   state_n = S_RD2;
            S_RD2:   state_n = S_RD3;
            S_RD3:   state_n = S_CMP;
            S_CMP:   state_n = S_WL1;
`ifdef POOL_FLATTEN_EN
            S_WL1:   state_n = S_WL2;
            S_WL2:   state_n = last ? S_DONE : S_RD0;
`else
            S_WL1:   state_n = last ? S_DONE : S_RD0;
`endif
            default: state_n = S_IDLE;
        endcase
    end

    // read data lags the address by one cycle, so pixel 0 arrives at the end of RD1
    pool_max4 #(.DATA_W(DATA_W)) u_max (
        .clk   (clk),
        .reset (reset),
        .load  (state == S_RD1),
        .update(state inside {S_RD2, S_RD3, S_CMP}),
        .din   (cm.cdata_rd),
        .max_q (max_q)
    );

    // window address {r, row, c, col} equals 2r*IMG_W + 2c + offset with no adder
    assign cm.crd      = rd;
    assign cm.cwr      = wr1 | wr2;
    assign cm.caddr_rd = rd ? ADDR_W'({r, row, c, col}) : '0;
    assign cm.caddr_wr = wr1 ? ADDR_W'({r, c}) : wr2 ? ADDR_W'(item) : '0;
    assign cm.cdata_wr = (wr1 | wr2) ? max_q : '0;
    assign cm.csel     = rd  ? (k ? CSEL_L0K1 : CSEL_L0K0) :
                         wr1 ? (k ? CSEL_L1K1 : CSEL_L1K0) :
                         wr2 ? CSEL_L2 : CSEL_IDLE;
    assign busy        = !(state inside {S_IDLE, S_DONE});
    assign done        = state == S_DONE;
endmodule

// File: tb/tb_conv_pool_flatten.sv
// tb_conv_pool_flatten: directed window table, random maps vs. a pooling model, abort/restart and port rules.
module tb_conv_pool_flatten;
    import conv_pkg::*;

    localparam int IW = 64, DW = 20, AW = 12, NP = 1024, HALF = 32;
`ifdef POOL_FLATTEN_EN
    localparam int RUN_CYC = 14336;
`else
    localparam int RUN_CYC = 12288;
`endif

    logic clk = 0, reset = 0, start = 0, busy, done;
    conv_pool_flatten_if #(.ADDR_W(AW), .DATA_W(DW)) cm();
    conv_pool_flatten #(.IMG_W(IW), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .cm(cm)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] l0 [2][IW*IW];
    logic [DW-1:0] l1 [2][NP];
    logic [DW-1:0] l2 [2*NP];

    always @(posedge clk) begin
        if (cm.crd) cm.cdata_rd <= (cm.csel == 3'b010) ? l0[1][cm.caddr_rd] : l0[0][cm.caddr_rd];
        if (cm.cwr)
            case (cm.csel)
                3'b011:  l1[0][cm.caddr_wr[9:0]] <= cm.cdata_wr;
                3'b100:  l1[1][cm.caddr_wr[9:0]] <= cm.cdata_wr;
                3'b101:  l2[cm.caddr_wr[10:0]] <= cm.cdata_wr;
                default: ;
            endcase
    end

    int viol = 0, l2_next = 0, errors = 0, checks = 0;

    always @(negedge clk) begin
        if (!reset || done) l2_next <= 0;
        else if (cm.cwr && cm.csel == 3'b101) l2_next <= l2_next + 1;
        if (reset && ((cm.crd && cm.cwr) ||
                      (!cm.crd && !cm.cwr && cm.csel != 3'b000) ||
                      (cm.crd && !(cm.csel inside {3'b001, 3'b010})) ||
                      (cm.cwr && !(cm.csel inside {3'b011, 3'b100, 3'b101})) ||
`ifndef POOL_FLATTEN_EN
                      (cm.csel == 3'b101) ||
`endif
                      (cm.cwr && cm.csel == 3'b101 && cm.caddr_wr != AW'(l2_next))))
            viol <= viol + 1;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int win_base(input int p);
        return (p / HALF) * 2 * IW + (p % HALF) * 2;
    endfunction

    task automatic model_check(input string tag);
        int b1, b2, base;
        logic [DW-1:0] win[4];
        logic [DW-1:0] m;
        b1 = 0;
        b2 = 0;
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < NP; p++) begin
                base = win_base(p);
                win = '{l0[k][base], l0[k][base+1], l0[k][base+IW], l0[k][base+IW+1]};
                m = win[0];
                foreach (win[i]) if ($signed(win[i]) > $signed(m)) m = win[i];
                if (l1[k][p] !== m) b1++;
                if (l2[2*p+k] !== m) b2++;
            end
        chk({tag, " l1 mismatches"}, b1, 0);
`ifdef POOL_FLATTEN_EN
        chk({tag, " l2 mismatches"}, b2, 0);
`endif
    endtask

    task automatic run(input int extra_at, output int bc, output int dc);
        bc = 0;
        dc = 0;
        @(negedge clk) start = 1;
        for (int i = 0; i < RUN_CYC + 50; i++) begin
            @(negedge clk);
            start = (i == extra_at);
            bc += int'(busy);
            dc += int'(done);
        end
    endtask

    task automatic fill_random();
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < IW*IW; a++) l0[k][a] = DW'($urandom);
    endtask

    typedef struct {
        bit            k;
        int            p;
        logic [DW-1:0] px0, px1, px2, px3;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t vt[7];

    initial begin
        int bc, dc, base;
        vt[0] = '{0, 33,   20'h01234, 20'h00000, 20'h00000, 20'h00000, 20'h01234};
        vt[1] = '{1, 0,    20'h00005, 20'h00007, 20'h00007, 20'h00003, 20'h00007};
        vt[2] = '{0, 0,    20'hFFFFE, 20'hFFFFF, 20'hFFFF0, 20'hFFFFD, 20'hFFFFF};
        vt[3] = '{1, 1023, 20'h80000, 20'h7FFFF, 20'h00000, 20'h00001, 20'h7FFFF};
        vt[4] = '{0, 31,   20'h00001, 20'h00002, 20'h00003, 20'h00004, 20'h00004};
        vt[5] = '{1, 992,  20'h00010, 20'h00010, 20'h00010, 20'h00010, 20'h00010};
        vt[6] = '{0, 500,  20'h80000, 20'h80000, 20'h80000, 20'h80001, 20'h80001};

        repeat (3) @(negedge clk);
        chk("reset outputs", {busy, done, cm.crd, cm.cwr, cm.caddr_rd, cm.caddr_wr, cm.cdata_wr, cm.csel}, 0);
        reset = 1;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 2; k++)
            for (int a = 0; a < IW*IW; a++) l0[k][a] = '0;
        foreach (vt[i]) begin
            base = win_base(vt[i].p);
            l0[vt[i].k][base]      = vt[i].px0;
            l0[vt[i].k][base+1]    = vt[i].px1;
            l0[vt[i].k][base+IW]   = vt[i].px2;
            l0[vt[i].k][base+IW+1] = vt[i].px3;
        end
        run(-1, bc, dc);
        chk("directed busy cycles", bc, RUN_CYC);
        chk("directed done pulses", dc, 1);
        foreach (vt[i]) begin
            chk($sformatf("vec%0d l1", i), l1[vt[i].k][vt[i].p], vt[i].exp);
`ifdef POOL_FLATTEN_EN
            chk($sformatf("vec%0d l2", i), l2[2*vt[i].p + vt[i].k], vt[i].exp);
`endif
        end
        model_check("directed");

        fill_random();
        run(100, bc, dc);
        chk("random busy cycles", bc, RUN_CYC);
        chk("random done pulses", dc, 1);
        model_check("random");

        fill_random();
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
        repeat (4998) @(negedge clk);
        reset = 0;
        #1;
        chk("abort outputs", {busy, done, cm.crd, cm.cwr, cm.caddr_rd, cm.caddr_wr, cm.cdata_wr, cm.csel}, 0);
        repeat (3) @(negedge clk);
        reset = 1;
        repeat (100) @(negedge clk);
        chk("idle after abort", {busy, done, cm.crd, cm.cwr}, 0);
        run(-1, bc, dc);
        chk("restart busy cycles", bc, RUN_CYC);
        chk("restart done pulses", dc, 1);
        model_check("restart");

        chk("port rule violations", viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
